// File: rtl/kan_layer_engine.sv
// Time-multiplexed KAN layer: one piecewise-linear function per cycle for forward
// evaluation and in-place table training. Define KAN_LAYER_SAT_EN to saturate instead of wrap.
module kan_layer_engine #(
    parameter int DW          = 32,
    parameter int N_IN        = 6,
    parameter int N_OUT       = 53,
    parameter int N_POINTS    = 14,
    parameter int XMIN        = -10000,
    parameter int DELTA_SHIFT = 17,
    parameter int ALPHA_SHIFT = 8,
    parameter int MULT        = 154,
    parameter int BASE_SHIFT  = 13,
    localparam int AW         = $clog2(N_IN * N_OUT * N_POINTS)
) (
    input  logic                  CLK100MHZ,
    input  logic                  CPU_RESETN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [N_IN*DW-1:0]    x_in,
    input  logic [N_OUT*DW-1:0]   delta_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_OUT*DW-1:0]   y_out,
    output logic [N_IN*DW-1:0]    back_out,
    output logic                  upd_err,
    input  logic                  ld_we,
    input  logic [AW-1:0]         ld_addr,
    input  logic [DW-1:0]         ld_data
);

    localparam int N_FN  = N_IN * N_OUT;
    localparam int N_TBL = N_FN * N_POINTS;
    localparam int KW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int JW    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int FNW   = (N_FN > 1) ? $clog2(N_FN) : 1;
    localparam int IW    = $clog2(N_POINTS);
    localparam int DSW   = DELTA_SHIFT;

    localparam logic signed [63:0] XMIN_L = 64'(XMIN);
    localparam logic signed [63:0] XMAX_L = XMIN_L + (64'(N_POINTS - 1) <<< DELTA_SHIFT);
    localparam logic signed [63:0] MULT_L = 64'(MULT);
    localparam logic [DSW-1:0]     OFF_LO = DSW'(512);
    localparam logic [DSW-1:0]     OFF_HI = DSW'((1 << DELTA_SHIFT) - 512);

`ifdef KAN_LAYER_SAT_EN
    localparam logic signed [63:0] SMAX = (64'sd1 <<< (DW - 1)) - 64'sd1;
    localparam logic signed [63:0] SMIN = -(64'sd1 <<< (DW - 1));
`endif

    function automatic logic [DW-1:0] fit(input logic signed [63:0] a);
`ifdef KAN_LAYER_SAT_EN
        if (a > SMAX)      fit = DW'(SMAX);
        else if (a < SMIN) fit = DW'(SMIN);
        else               fit = DW'(a);
`else
        fit = DW'(a);
`endif
    endfunction

    // states: IDLE wait cmd | RUN_F evaluate | SCALE flush last row | RUN_U train | HOLD present result
    typedef enum logic [2:0] {S_IDLE, S_RUN_F, S_SCALE, S_RUN_U, S_HOLD} state_t;

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [JW-1:0]          j_q, j_d;
    logic [N_IN*DW-1:0]     x_q, x_d;
    logic [N_OUT*DW-1:0]    delta_q, delta_d;
    logic signed [63:0]     acc_q, acc_d;
    logic signed [63:0]     row_q, row_d;
    logic [KW-1:0]          row_k_q, row_k_d;
    logic                   row_pend_q, row_pend_d;
    logic [N_OUT*DW-1:0]    y_q, y_d;
    logic [N_IN*DW-1:0]     back_q, back_d;
    logic signed [63:0]     back_acc_q [N_IN];
    logic signed [63:0]     back_acc_d [N_IN];
    logic                   ctx_valid_q, ctx_valid_d;
    logic                   out_valid_q, out_valid_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   upd_err_q, upd_err_d;

    logic [DW-1:0]          tbl_mem     [N_TBL];
    logic [IW-1:0]          ctx_idx_mem [N_FN];
    logic [DSW-1:0]         ctx_off_mem [N_FN];

    logic                   upd_mode, ld_ok, accept, last_fn;
    logic [FNW-1:0]         fn_cur;
    logic signed [63:0]     xs, rr, fa, fb, diff, off64, interp, dk, bc, rl, tt, scaled;
    logic                   lo_edge, hi_edge;
    logic [IW-1:0]          c_idx, rd_idx;
    logic [DSW-1:0]         c_off, rd_off;
    logic [AW-1:0]          addr_a, addr_b, tbl_wa;
    logic [DW-1:0]          v, na, nb, tbl_wd_a;
    logic                   tbl_we_a, tbl_we_b, ctx_we;

    always_comb begin
        upd_mode = (state_q == S_RUN_U);
        fn_cur   = FNW'(32'(k_q) * N_IN + 32'(j_q));
        xs       = 64'($signed(x_q[32'(j_q)*DW +: DW]));
        rr       = xs - XMIN_L;
        lo_edge  = (xs <= XMIN_L);
        hi_edge  = !lo_edge && (xs >= XMAX_L);
        if (lo_edge) begin
            c_idx = '0;
            c_off = OFF_LO;
        end else if (hi_edge) begin
            c_idx = IW'(N_POINTS - 2);
            c_off = OFF_HI;
        end else begin
            c_idx = IW'(rr >>> DELTA_SHIFT);
            c_off = DSW'(rr);
        end
        // Training reuses the segment/offset captured by the last forward pass.
        rd_idx = upd_mode ? ctx_idx_mem[fn_cur] : c_idx;
        rd_off = upd_mode ? ctx_off_mem[fn_cur] : c_off;
        addr_a = AW'(32'(fn_cur) * N_POINTS + 32'(rd_idx));
        addr_b = addr_a + AW'(1);
        fa     = 64'($signed(tbl_mem[addr_a]));
        fb     = 64'($signed(tbl_mem[addr_b]));
        diff   = fb - fa;
        off64  = 64'(rd_off);
        interp = fa + ((diff * off64) >>> DELTA_SHIFT);
        v      = fit(lo_edge ? fa : (hi_edge ? fb : interp));
        dk     = 64'($signed(delta_q[32'(k_q)*DW +: DW]));
        bc     = (diff * dk) >>> DELTA_SHIFT;
        rl     = dk >>> ALPHA_SHIFT;
        tt     = (rl * off64) >>> DELTA_SHIFT;
        nb     = fit(fb + tt);
        na     = fit(fa + rl - tt);
        scaled = (row_q * MULT_L) >>> BASE_SHIFT;
    end

    always_comb begin
        accept   = cmd_valid && cmd_ready_q;
        last_fn  = (k_q == KW'(N_OUT - 1)) && (j_q == JW'(N_IN - 1));
        ld_ok    = (state_q == S_IDLE) && ld_we;
        tbl_we_a = ld_ok || (upd_mode && ctx_valid_q);
        tbl_we_b = upd_mode && ctx_valid_q;
        tbl_wa   = ld_ok ? ld_addr : addr_a;
        tbl_wd_a = ld_ok ? ld_data : na;
        ctx_we   = (state_q == S_RUN_F);
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        j_d         = j_q;
        x_d         = x_q;
        delta_d     = delta_q;
        acc_d       = acc_q;
        row_d       = row_q;
        row_k_d     = row_k_q;
        row_pend_d  = 1'b0;
        y_d         = y_q;
        back_d      = back_q;
        back_acc_d  = back_acc_q;
        ctx_valid_d = ctx_valid_q;
        out_valid_d = out_valid_q;
        cmd_ready_d = cmd_ready_q;
        upd_err_d   = upd_err_q;

        if (state_q == S_RUN_F || state_q == S_RUN_U) begin
            if (j_q == JW'(N_IN - 1)) begin
                j_d = '0;
                k_d = (k_q == KW'(N_OUT - 1)) ? '0 : k_q + KW'(1);
            end else begin
                j_d = j_q + JW'(1);
            end
        end

        // Completed rows are scaled one cycle later, so SCALE only flushes the final row.
        if (row_pend_q)
            y_d[32'(row_k_q)*DW +: DW] = fit(scaled);

        case (state_q)
            S_IDLE: begin
                if (ld_ok)
                    ctx_valid_d = 1'b0;
                if (accept) begin
                    k_d         = '0;
                    j_d         = '0;
                    cmd_ready_d = 1'b0;
                    upd_err_d   = 1'b0;
                    if (cmd_op) begin
                        state_d = S_RUN_U;
                        delta_d = delta_in;
                        for (int i = 0; i < N_IN; i++)
                            back_acc_d[i] = '0;
                    end else begin
                        state_d = S_RUN_F;
                        x_d     = x_in;
                    end
                end
            end
            S_RUN_F: begin
                acc_d = ((j_q == '0) ? 64'sd0 : acc_q) + 64'($signed(v));
                if (j_q == JW'(N_IN - 1)) begin
                    row_d      = acc_d;
                    row_k_d    = k_q;
                    row_pend_d = 1'b1;
                end
                if (last_fn)
                    state_d = S_SCALE;
            end
            S_SCALE: begin
                state_d     = S_HOLD;
                out_valid_d = 1'b1;
                ctx_valid_d = 1'b1;
            end
            S_RUN_U: begin
                if (ctx_valid_q)
                    back_acc_d[j_q] = back_acc_q[j_q] + bc;
                if (k_q == KW'(N_OUT - 1))
                    back_d[32'(j_q)*DW +: DW] = ctx_valid_q ? fit(back_acc_d[j_q]) : '0;
                if (last_fn) begin
                    state_d     = S_HOLD;
                    out_valid_d = 1'b1;
                    upd_err_d   = !ctx_valid_q;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Tables and context survive reset.
    always_ff @(posedge CLK100MHZ) begin
        if (tbl_we_a)
            tbl_mem[tbl_wa] <= tbl_wd_a;
        if (tbl_we_b)
            tbl_mem[addr_b] <= nb;
        if (ctx_we) begin
            ctx_idx_mem[fn_cur] <= c_idx;
            ctx_off_mem[fn_cur] <= c_off;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            j_q         <= '0;
            x_q         <= '0;
            delta_q     <= '0;
            acc_q       <= '0;
            row_q       <= '0;
            row_k_q     <= '0;
            row_pend_q  <= 1'b0;
            y_q         <= '0;
            back_q      <= '0;
            for (int i = 0; i < N_IN; i++)
                back_acc_q[i] <= '0;
            ctx_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            upd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            j_q         <= j_d;
            x_q         <= x_d;
            delta_q     <= delta_d;
            acc_q       <= acc_d;
            row_q       <= row_d;
            row_k_q     <= row_k_d;
            row_pend_q  <= row_pend_d;
            y_q         <= y_d;
            back_q      <= back_d;
            back_acc_q  <= back_acc_d;
            ctx_valid_q <= ctx_valid_d;
            out_valid_q <= out_valid_d;
            cmd_ready_q <= cmd_ready_d;
            upd_err_q   <= upd_err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign out_valid = out_valid_q;
    assign y_out     = y_q;
    assign back_out  = back_q;
    assign upd_err   = upd_err_q;

endmodule
